dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, data-memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have port clk  in  1  rising-edge clock, the single clock of the block.
REQ-004 SHALL have port resetN  in  1  asynchronous active-low reset.
REQ-005 SHALL have port reqValid  in  2  per-requester access request; index 0 = core LSU, 1 = DMA.
REQ-006 SHALL have port reqReady  out  2  one-hot acceptance of a request.
REQ-007 SHALL have ports reqWrite in 2x1, reqAddress in 2xADDR_W, reqFunct3 in 2x3, reqWriteData in 2xDATA_W: per-requester access attributes.
REQ-008 SHALL have ports rspValid out 2, rspData out DATA_W, rspError out 1: completion pulse, load data, misalignment flag.
REQ-009 SHALL have ports memAddress out ADDR_W, memFunct3 out 3, memReadMemory out 1, memWriteMemory out 1, memWriteData out DATA_W, memReadData in DATA_W: data-memory port (combinational read, write at clk rise).

Function
REQ-010 SHALL run FSM IDLE -> ACCESS -> RESP -> IDLE, one access in flight.
REQ-011 IDLE: if any reqValid set, grant one, drive reqReady[g]=1 that cycle, latch requester index and attributes at the edge, go ACCESS; else stay IDLE.
REQ-012 ACCESS: drive mem* from latched attributes for exactly one cycle; read captures memReadData into rspData at the edge; write asserts memWriteMemory for that cycle only.
REQ-013 RESP: rspValid[g]=1 for exactly one cycle; rspData holds load data (0 for stores); then IDLE.
REQ-014 Latency: accept at edge N, ACCESS in cycle N+1, rspValid in cycle N+2; max throughput one access per 3 cycles.
REQ-015 Misaligned (half with address[0]=1, word with address[1:0]!=0): ACCESS SHALL keep memReadMemory=memWriteMemory=0; RESP gives rspError=1, rspData=0.
REQ-016 Outside ACCESS: memReadMemory=0, memWriteMemory=0, memAddress=0, memWriteData=0, memFunct3=0.
REQ-017 reqReady SHALL be 0 in ACCESS and RESP; unaccepted requesters hold their request and are not lost.
REQ-018 Requests arriving or dropping mid-access SHALL NOT alter the latched access.
REQ-019 reqFunct3 SHALL pass unmodified; sign/zero extension stays in memory.

Reset
REQ-020 resetN low SHALL immediately force IDLE, reqReady=0, rspValid=0, rspError=0, rspData=0, all mem* outputs 0, last-grant register = 1 (DMA).
REQ-021 Reset during ACCESS SHALL abort it: no write committed at the next edge, no response issued.

Configuration
REQ-022 DMEM_ARB_RR_EN defined: round-robin; on simultaneous requests, the requester not granted last wins; last-grant updates on every grant.
REQ-023 DMEM_ARB_RR_EN undefined: fixed priority, core (0) always beats DMA (1); last-grant register absent.

Structure
REQ-024 Package dmem_arb_pkg SHALL hold FSM state enum, funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5), requester index constants CORE=0, DMA=1.
REQ-025 Grant selection SHALL be sub-module dmem_arb_picker (valid vector, last grant -> one-hot grant), combinational.

Verification
REQ-026 Word 4 preloaded 32'hAABBCCDD; core reads address 17, funct3=0 -> rspValid[0] two cycles after accept, rspData=32'hFFFFFFCC, rspError=0.
REQ-027 DMA writes 32'hABCDABCD to address 3, funct3=0, then core LB address 3 -> rspData=32'hFFFFFFCD; memWriteMemory high exactly one cycle.
REQ-028 Both requesters valid every cycle for 4 grants -> RR_EN: grants 0,1,0,1; without macro: 0,0,0,0 with DMA held, reqReady[1] never high.
REQ-029 Core LW address 6 -> no mem strobe, rspError=1, rspData=0; then LH address 6 writing 32'hAAAA and LH readback -> 32'hFFFFAAAA.
REQ-030 resetN pulsed low during ACCESS of a write of 32'h10101010 to address 8 -> memory word 2 unchanged, no rspValid, FSM IDLE, all outputs 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Holds the FSM state enum, funct3 encodings, requester indices and the alignment check.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arbState_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic CORE = 1'b0;
    localparam logic DMA  = 1'b1;

    // funct3[1:0] encodes the access size: 0 = byte, 1 = half, 2 = word.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLsb);
        return ((size == 2'd1) && addrLsb[0]) || ((size == 2'd2) && (addrLsb != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_arb_picker.sv
// Combinational grant selection: turns the request vector and the last grant into a one-hot grant.
// When both request, the one that was not granted last wins; a fixed lastGrant of DMA gives core priority.
module dmem_arb_picker
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       lastGrant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o    = 2'b00;
        grant_o[0] = valid_i[0] && (!valid_i[1] || (lastGrant_i == DMA));
        grant_o[1] = valid_i[1] && (!valid_i[0] || (lastGrant_i == CORE));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core LSU and DMA onto one data-memory port, one access in flight (IDLE -> ACCESS -> RESP).
// Define DMEM_ARB_RR_EN for round-robin; otherwise the core has fixed priority over the DMA.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [1:0]             reqValid,
    output logic [1:0]             reqReady,
    input  logic [1:0]             reqWrite,
    input  logic [1:0][ADDR_W-1:0] reqAddress,
    input  logic [1:0][2:0]        reqFunct3,
    input  logic [1:0][DATA_W-1:0] reqWriteData,
    output logic [1:0]             rspValid,
    output logic [DATA_W-1:0]      rspData,
    output logic                   rspError,
    output logic [ADDR_W-1:0]      memAddress,
    output logic [2:0]             memFunct3,
    output logic                   memReadMemory,
    output logic                   memWriteMemory,
    output logic [DATA_W-1:0]      memWriteData,
    input  logic [DATA_W-1:0]      memReadData
);

    arbState_e         state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rspData_q, rspData_d;
    logic              rspError_q, rspError_d;
    logic [1:0]        grant;
    logic              lastGrant;
    logic              accept;
    logic              misaligned;

`ifdef DMEM_ARB_RR_EN
    logic lastGrant_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lastGrant_q <= DMA;
        end else if (accept) begin
            lastGrant_q <= grant[1];
        end
    end

    assign lastGrant = lastGrant_q;
`else
    assign lastGrant = DMA;
`endif

    dmem_arb_picker uPicker (
        .valid_i     (reqValid),
        .lastGrant_i (lastGrant),
        .grant_o     (grant)
    );

    // resetN gates acceptance so nothing is granted while reset is held.
    assign accept     = (state_q == ST_IDLE) && resetN && (|reqValid);
    assign misaligned = isMisaligned(f3_q[1:0], addr_q[1:0]);

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        write_d        = write_q;
        addr_d         = addr_q;
        f3_d           = f3_q;
        wdata_d        = wdata_q;
        rspData_d      = rspData_q;
        rspError_d     = rspError_q;
        reqReady       = 2'b00;
        rspValid       = 2'b00;
        memAddress     = '0;
        memFunct3      = 3'd0;
        memReadMemory  = 1'b0;
        memWriteMemory = 1'b0;
        memWriteData   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    reqReady = grant;
                    gnt_d    = grant[1];
                    write_d  = reqWrite[grant[1]];
                    addr_d   = reqAddress[grant[1]];
                    f3_d     = reqFunct3[grant[1]];
                    wdata_d  = reqWriteData[grant[1]];
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                memAddress     = addr_q;
                memFunct3      = f3_q;
                memWriteData   = wdata_q;
                memReadMemory  = !write_q && !misaligned;
                memWriteMemory = write_q && !misaligned;
                rspError_d     = misaligned;
                rspData_d      = (write_q || misaligned) ? '0 : memReadData;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                rspValid = gnt_q ? 2'b10 : 2'b01;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            gnt_q      <= CORE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            f3_q       <= 3'd0;
            wdata_q    <= '0;
            rspData_q  <= '0;
            rspError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            f3_q       <= f3_d;
            wdata_q    <= wdata_d;
            rspData_q  <= rspData_d;
            rspError_q <= rspError_d;
        end
    end

    assign rspData  = (state_q == ST_RESP) ? rspData_q : '0;
    assign rspError = (state_q == ST_RESP) && rspError_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model that does sign/zero extension.
// Expected grant order follows DMEM_ARB_RR_EN when the bench is built with it.
module tb_dmem_arbiter;

    logic             clk;
    logic             resetN;
    logic [1:0]       reqValid;
    logic [1:0]       reqReady;
    logic [1:0]       reqWrite;
    logic [1:0][31:0] reqAddress;
    logic [1:0][2:0]  reqFunct3;
    logic [1:0][31:0] reqWriteData;
    logic [1:0]       rspValid;
    logic [31:0]      rspData;
    logic             rspError;
    logic [31:0]      memAddress;
    logic [2:0]       memFunct3;
    logic             memReadMemory;
    logic             memWriteMemory;
    logic [31:0]      memWriteData;
    logic [31:0]      memReadData;

    logic [7:0]       mem [0:63];
    logic [5:0]       rdAddr;
    logic [5:0]       wrAddr;
    int               writeCycles;
    int               readCycles;
    int               compared;
    int               mismatched;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqWrite       (reqWrite),
        .reqAddress     (reqAddress),
        .reqFunct3      (reqFunct3),
        .reqWriteData   (reqWriteData),
        .rspValid       (rspValid),
        .rspData        (rspData),
        .rspError       (rspError),
        .memAddress     (memAddress),
        .memFunct3      (memFunct3),
        .memReadMemory  (memReadMemory),
        .memWriteMemory (memWriteMemory),
        .memWriteData   (memWriteData),
        .memReadData    (memReadData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: combinational read with extension done here, writes at the rising edge.
    always_comb begin
        rdAddr = memAddress[5:0];
        case (memFunct3)
            3'd0:    memReadData = {{24{mem[rdAddr][7]}}, mem[rdAddr]};
            3'd1:    memReadData = {{16{mem[rdAddr + 6'd1][7]}}, mem[rdAddr + 6'd1], mem[rdAddr]};
            3'd4:    memReadData = {24'h0, mem[rdAddr]};
            3'd5:    memReadData = {16'h0, mem[rdAddr + 6'd1], mem[rdAddr]};
            default: memReadData = {mem[rdAddr + 6'd3], mem[rdAddr + 6'd2], mem[rdAddr + 6'd1], mem[rdAddr]};
        endcase
    end

    always @(posedge clk) begin
        wrAddr = memAddress[5:0];
        if (memWriteMemory) begin
            writeCycles <= writeCycles + 1;
            mem[wrAddr] <= memWriteData[7:0];
            if (memFunct3[1:0] != 2'd0) mem[wrAddr + 6'd1] <= memWriteData[15:8];
            if (memFunct3[1:0] == 2'd2) begin
                mem[wrAddr + 6'd2] <= memWriteData[23:16];
                mem[wrAddr + 6'd3] <= memWriteData[31:24];
            end
        end
        if (memReadMemory) readCycles <= readCycles + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One complete access from a single requester, checking every phase.
    task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                                 input logic [31:0] wd, input logic [31:0] expData, input logic expErr);
        logic [1:0] oneHot;
        int w0;
        int r0;
        oneHot = (idx == 1) ? 2'b10 : 2'b01;
        w0 = writeCycles;
        r0 = readCycles;
        @(negedge clk);
        reqValid[idx]     = 1'b1;
        reqWrite[idx]     = wr;
        reqAddress[idx]   = addr;
        reqFunct3[idx]    = f3;
        reqWriteData[idx] = wd;
        #1;
        checkOutput("reqReady", {30'd0, reqReady}, {30'd0, oneHot});
        @(negedge clk);
        reqValid[idx]     = 1'b0;
        reqWrite[idx]     = ~wr;
        reqAddress[idx]   = addr ^ 32'h10;
        reqWriteData[idx] = ~wd;
        #1;
        checkOutput("accessReady", {30'd0, reqReady}, 32'd0);
        checkOutput("accessAddr", memAddress, addr);
        checkOutput("accessFunct3", {29'd0, memFunct3}, {29'd0, f3});
        checkOutput("accessWr", {31'd0, memWriteMemory}, {31'd0, wr && !expErr});
        checkOutput("accessRd", {31'd0, memReadMemory}, {31'd0, !wr && !expErr});
        checkOutput("accessRspValid", {30'd0, rspValid}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rspValid", {30'd0, rspValid}, {30'd0, oneHot});
        checkOutput("rspData", rspData, expData);
        checkOutput("rspError", {31'd0, rspError}, {31'd0, expErr});
        checkOutput("writeStrobes", writeCycles - w0, (wr && !expErr) ? 32'd1 : 32'd0);
        checkOutput("readStrobes", readCycles - r0, (!wr && !expErr) ? 32'd1 : 32'd0);
        checkOutput("memIdle", {memAddress[30:0], memWriteMemory}, 32'd0);
    endtask

    logic [1:0] expGrant [0:3];

    initial begin
        compared     = 0;
        mismatched   = 0;
        writeCycles  = 0;
        readCycles   = 0;
        resetN       = 1'b0;
        reqValid     = 2'b00;
        reqWrite     = 2'b00;
        reqAddress   = '0;
        reqFunct3    = '0;
        reqWriteData = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        {mem[19], mem[18], mem[17], mem[16]} = 32'hAABBCCDD;
        {mem[11], mem[10], mem[9], mem[8]}   = 32'h55667788;
`ifdef DMEM_ARB_RR_EN
        expGrant[0] = 2'b01; expGrant[1] = 2'b10; expGrant[2] = 2'b01; expGrant[3] = 2'b10;
`else
        expGrant[0] = 2'b01; expGrant[1] = 2'b01; expGrant[2] = 2'b01; expGrant[3] = 2'b01;
`endif

        repeat (2) @(negedge clk);
        reqValid = 2'b01;
        #1;
        checkOutput("resetReady", {30'd0, reqReady}, 32'd0);
        checkOutput("resetRspValid", {30'd0, rspValid}, 32'd0);
        checkOutput("resetRspData", rspData, 32'd0);
        checkOutput("resetMem", {memAddress[28:0], memFunct3}, 32'd0);
        checkOutput("resetStrobes", {29'd0, rspError, memReadMemory, memWriteMemory}, 32'd0);
        reqValid = 2'b00;
        resetN   = 1'b1;

        $display("[TB] contention: both requesters held valid");
        @(negedge clk);
        reqValid        = 2'b11;
        reqFunct3[0]    = 3'd2;
        reqFunct3[1]    = 3'd2;
        reqAddress[0]   = 32'd16;
        reqAddress[1]   = 32'd16;
        for (int g = 0; g < 4; g++) begin
            #1;
            checkOutput($sformatf("grant%0d", g), {30'd0, reqReady}, {30'd0, expGrant[g]});
            @(negedge clk);
            @(negedge clk);
            #1;
            checkOutput($sformatf("grantRsp%0d", g), {30'd0, rspValid}, {30'd0, expGrant[g]});
            checkOutput($sformatf("grantData%0d", g), rspData, 32'hAABBCCDD);
            @(negedge clk);
        end
        reqValid = 2'b10;
        #1;
        checkOutput("dmaHeld", {30'd0, reqReady}, 32'd2);
        @(negedge clk);
        reqValid = 2'b00;
        @(negedge clk);
        #1;
        checkOutput("dmaRsp", {30'd0, rspValid}, 32'd2);

        $display("[TB] loads, stores and alignment");
        applyStimulus(0, 1'b0, 32'd17, 3'd0, 32'd0, 32'hFFFFFFCC, 1'b0);
        applyStimulus(1, 1'b1, 32'd3, 3'd0, 32'hABCDABCD, 32'd0, 1'b0);
        applyStimulus(0, 1'b0, 32'd3, 3'd0, 32'd0, 32'hFFFFFFCD, 1'b0);
        applyStimulus(0, 1'b0, 32'd6, 3'd2, 32'd0, 32'd0, 1'b1);
        applyStimulus(0, 1'b1, 32'd6, 3'd1, 32'h0000AAAA, 32'd0, 1'b0);
        applyStimulus(0, 1'b0, 32'd6, 3'd1, 32'd0, 32'hFFFFAAAA, 1'b0);
        applyStimulus(1, 1'b0, 32'd6, 3'd5, 32'd0, 32'h0000AAAA, 1'b0);
        applyStimulus(1, 1'b0, 32'd17, 3'd4, 32'd0, 32'h000000CC, 1'b0);

        $display("[TB] reset during a write access");
        @(negedge clk);
        reqValid        = 2'b01;
        reqWrite[0]     = 1'b1;
        reqAddress[0]   = 32'd8;
        reqFunct3[0]    = 3'd2;
        reqWriteData[0] = 32'h10101010;
        #1;
        checkOutput("abortReady", {30'd0, reqReady}, 32'd1);
        @(negedge clk);
        reqValid = 2'b00;
        #1;
        checkOutput("abortPreWr", {31'd0, memWriteMemory}, 32'd1);
        #1;
        resetN = 1'b0;
        #1;
        checkOutput("abortWr", {31'd0, memWriteMemory}, 32'd0);
        checkOutput("abortMem", memAddress | memWriteData, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("abortRspValid", {30'd0, rspValid}, 32'd0);
        checkOutput("abortWord2", {mem[11], mem[10], mem[9], mem[8]}, 32'h55667788);
        resetN = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("abortIdleRsp", {29'd0, rspError, rspValid}, 32'd0);
        checkOutput("abortIdleMem", {29'd0, reqReady, memReadMemory | memWriteMemory}, 32'd0);
        applyStimulus(0, 1'b0, 32'd8, 3'd2, 32'd0, 32'h55667788, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
